// File: rtl/reg_dump.sv
// reg_dump: walks register-file indices 0..31, presenting each word on a
// valid/ready output port, then pulses done.
// Optional feature macro: REG_DUMP_CHECKSUM_EN -- appends a 32-bit XOR of all
// captured words as an extra word with dumpIdx=32.
module reg_dump (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic [4:0]  readReg,
    input  logic [31:0] readData,
    output logic [31:0] dumpData,
    output logic [5:0]  dumpIdx,
    output logic        dumpValid,
    input  logic        dumpReady,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {IDLE, LOAD, SEND, DONE} state_t;

    state_t     state;
    logic [4:0] index;
`ifdef REG_DUMP_CHECKSUM_EN
    logic [31:0] csum;       // running XOR of captured register words
    logic        csumPhase;  // set once word 31 has been accepted
`endif

    // Read address comes straight from the counter so readData is valid in LOAD.
    assign readReg = index;
    assign busy    = (state != IDLE);

    // Dump sequencer: capture in LOAD, hold until handshake in SEND.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            index     <= 5'd0;
            dumpData  <= 32'd0;
            dumpIdx   <= 6'd0;
            dumpValid <= 1'b0;
            done      <= 1'b0;
`ifdef REG_DUMP_CHECKSUM_EN
            csum      <= 32'd0;
            csumPhase <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        index <= 5'd0;
                        state <= LOAD;
`ifdef REG_DUMP_CHECKSUM_EN
                        csum      <= 32'd0;
                        csumPhase <= 1'b0;
`endif
                    end
                end
                LOAD: begin
`ifdef REG_DUMP_CHECKSUM_EN
                    // The checksum word reuses the LOAD/SEND pair so it costs
                    // the same two cycles as a register word.
                    if (csumPhase) begin
                        dumpData <= csum;
                        dumpIdx  <= 6'd32;
                    end else begin
                        dumpData <= readData;
                        dumpIdx  <= {1'b0, index};
                        csum     <= csum ^ readData;
                    end
`else
                    dumpData <= readData;
                    dumpIdx  <= {1'b0, index};
`endif
                    dumpValid <= 1'b1;
                    state     <= SEND;
                end
                SEND: begin
                    if (dumpValid && dumpReady) begin
                        dumpValid <= 1'b0;
`ifdef REG_DUMP_CHECKSUM_EN
                        if (csumPhase) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else if (index == 5'd31) begin
                            // index stays at 31; no wrap of readReg
                            csumPhase <= 1'b1;
                            state     <= LOAD;
                        end else begin
                            index <= index + 5'd1;
                            state <= LOAD;
                        end
`else
                        if (index == 5'd31) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            index <= index + 5'd1;
                            state <= LOAD;
                        end
`endif
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_reg_dump.sv
// Bench for reg_dump: a stimulus process pushes expected words into a
// scoreboard queue; a monitor pops and compares on every output handshake.
module tb_reg_dump;

`ifdef REG_DUMP_CHECKSUM_EN
    localparam int NW      = 33;
    localparam int EXP_CYC = 68;
`else
    localparam int NW      = 32;
    localparam int EXP_CYC = 66;
`endif

    logic        clk;
    logic        rst;
    logic        start;
    logic [4:0]  readReg;
    logic [31:0] readData;
    logic [31:0] dumpData;
    logic [5:0]  dumpIdx;
    logic        dumpValid;
    logic        dumpReady;
    logic        busy;
    logic        done;

    logic [31:0] rf [32];

    typedef struct {
        logic [5:0]  idx;
        logic [31:0] data;
    } exp_t;
    exp_t sbQ[$];

    int total = 0;
    int bad   = 0;
    int wordCnt = 0;
    int doneCnt = 0;
    logic [31:0] last20;
    logic [31:0] lastCsum;
    int cyc;

    reg_dump dut (
        .clk(clk), .rst(rst), .start(start), .readReg(readReg),
        .readData(readData), .dumpData(dumpData), .dumpIdx(dumpIdx),
        .dumpValid(dumpValid), .dumpReady(dumpReady), .busy(busy), .done(done)
    );

    // Combinational register-file read
    assign readData = rf[readReg];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Monitor: a word is consumed at the next posedge when valid && ready here.
    always @(negedge clk) begin : mon
        exp_t e;
        if (!rst && dumpValid && dumpReady) begin
            wordCnt++;
            if (dumpIdx == 6'd20) last20 = dumpData;
            if (dumpIdx == 6'd32) lastCsum = dumpData;
            if (sbQ.size() == 0) begin
                total++;
                bad++;
                $display("FAIL sb_extra: got idx %0d data %h, want no word", dumpIdx, dumpData);
            end else begin
                e = sbQ.pop_front();
                check("sb_idx", {26'd0, dumpIdx}, {26'd0, e.idx});
                check("sb_data", dumpData, e.data);
            end
        end
        if (!rst && done) doneCnt++;
    end

    task automatic pushDump();
        exp_t e;
        logic [31:0] x;
        x = 32'd0;
        for (int i = 0; i < 32; i++) begin
            e.idx  = 6'(i);
            e.data = rf[i];
            x      = x ^ rf[i];
            sbQ.push_back(e);
        end
`ifdef REG_DUMP_CHECKSUM_EN
        e.idx  = 6'd32;
        e.data = x;
        sbQ.push_back(e);
`endif
    endtask

    task automatic clearCnt();
        wordCnt = 0;
        doneCnt = 0;
    endtask

    // Caller has raised start in the current cycle (counted as cycle 1).
    task automatic waitDone(input bit restart, output int c);
        bit ok;
        ok = 0;
        c  = 1;
        for (int k = 0; k < 300; k++) begin
            @(posedge clk); #1;
            if (k == 0) start = 1'b0;
            c++;
            if (done) begin
                ok = 1;
                if (restart) start = 1'b1;
                @(posedge clk); #1;
                start = 1'b0;
                break;
            end
        end
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL done_timeout: got no done, want done within 300 cycles");
        end
    endtask

    // Returns at the negedge of the LOAD cycle for index k.
    task automatic waitLoad(input int k);
        bit ok;
        ok = 0;
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            if (busy && !dumpValid && !done && readReg == 5'(k)) begin
                ok = 1;
                break;
            end
        end
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL load_timeout: got no LOAD of %0d, want one within 300 cycles", k);
        end
    endtask

    task automatic checkEnd(input string name);
        check({name, "_words"}, 32'(wordCnt), 32'(NW));
        check({name, "_done"}, 32'(doneCnt), 32'd1);
        check({name, "_sbempty"}, 32'(sbQ.size()), 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        dumpReady = 1'b1;
        for (int i = 0; i < 32; i++) rf[i] = 32'(i) * 32'h01010101;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_valid", {31'd0, dumpValid}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_readReg", {27'd0, readReg}, 32'd0);
        check("rst_idx", {26'd0, dumpIdx}, 32'd0);
        check("rst_data", dumpData, 32'd0);
        @(posedge clk); #1 rst = 1'b0;

        // Full dump, ready held high: order, data and latency
        clearCnt(); pushDump();
        @(posedge clk); #1 start = 1'b1;
        waitDone(0, cyc);
        check("basic_cycles", 32'(cyc), 32'(EXP_CYC));
        checkEnd("basic");

        // Consumer stalls on word 7 for 5 cycles
        clearCnt(); pushDump();
        @(posedge clk); #1 start = 1'b1;
        fork
            waitDone(0, cyc);
            begin
                waitLoad(7);
                dumpReady = 1'b0;
                repeat (5) begin
                    @(negedge clk);
                    check("stall_data", dumpData, 32'h07070707);
                    check("stall_idx", {26'd0, dumpIdx}, 32'd7);
                    check("stall_valid", {31'd0, dumpValid}, 32'd1);
                end
                @(posedge clk); #1 dumpReady = 1'b1;
            end
        join
        checkEnd("stall");

        // Reset while word 12 is waiting for a handshake
        clearCnt(); pushDump();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        waitLoad(12);
        @(posedge clk); #1;
        check("pre_rst_idx", {26'd0, dumpIdx}, 32'd12);
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        check("midrst_valid", {31'd0, dumpValid}, 32'd0);
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_words", 32'(wordCnt), 32'd12);
        repeat (5) @(posedge clk);
        #1 check("midrst_noresume", {31'd0, busy}, 32'd0);
        sbQ.delete();
        clearCnt(); pushDump();
        @(posedge clk); #1 start = 1'b1;
        waitDone(0, cyc);
        checkEnd("restart");

        // start re-pulsed mid-dump and during DONE is ignored
        clearCnt(); pushDump();
        @(posedge clk); #1 start = 1'b1;
        fork
            waitDone(1, cyc);
            begin
                waitLoad(3);
                @(posedge clk); #1 start = 1'b1;
                @(posedge clk); #1 start = 1'b0;
            end
        join
        repeat (80) @(posedge clk);
        #1 check("ignore_idle", {31'd0, busy}, 32'd0);
        checkEnd("ignore");

        // Write to reg 20 on the same edge as its capture yields the old value
        clearCnt(); pushDump();
        @(posedge clk); #1 start = 1'b1;
        fork
            waitDone(0, cyc);
            begin
                waitLoad(20);
                // nonblocking so the write lands after the DUT samples readData
                @(posedge clk) rf[20] <= 32'hDEADBEEF;
            end
        join
        check("wb_old", last20, 32'h14141414);
        checkEnd("wb1");
        clearCnt(); pushDump();
        @(posedge clk); #1 start = 1'b1;
        waitDone(0, cyc);
        check("wb_new", last20, 32'hDEADBEEF);
        checkEnd("wb2");

`ifdef REG_DUMP_CHECKSUM_EN
        // Checksum word contents
        for (int i = 0; i < 32; i++) rf[i] = 32'(i);
        clearCnt(); pushDump();
        @(posedge clk); #1 start = 1'b1;
        waitDone(0, cyc);
        check("csum_zero", lastCsum, 32'h00000000);
        checkEnd("csum1");
        rf[5] = 32'hFFFFFFFF;
        clearCnt(); pushDump();
        @(posedge clk); #1 start = 1'b1;
        waitDone(0, cyc);
        check("csum_ff", lastCsum, 32'hFFFFFFFA);
        checkEnd("csum2");
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/reg_dump.md
REG_DUMP -- requirements
Module: reg_dump

Interface
REQ-001 The module SHALL have ports: clk  input  1  rising-edge clock, sole clock domain.
REQ-002 The module SHALL have ports: rst  input  1  reset, synchronous, active-high.
REQ-003 The module SHALL have ports: start  input  1  dump request, sampled only in IDLE.
REQ-004 The module SHALL have ports: readReg  output  5  register-file read address, driven directly from the index counter.
REQ-005 The module SHALL have ports: readData  input  32  register-file read data, combinational from readReg in the same cycle.
REQ-006 The module SHALL have ports: dumpData  output  32  registered output word.
REQ-007 The module SHALL have ports: dumpIdx  output  6  index of dumpData (0..31 registers, 32 checksum).
REQ-008 The module SHALL have ports: dumpValid  output  1  dumpData/dumpIdx valid.
REQ-009 The module SHALL have ports: dumpReady  input  1  consumer accepts the word.
REQ-010 The module SHALL have ports: busy  output  1  high in every state except IDLE.
REQ-011 The module SHALL have ports: done  output  1  one-cycle pulse at dump completion.

Function
REQ-012 FSM states SHALL be IDLE, LOAD, SEND, DONE; encoding is free.
REQ-013 IDLE with start=1 SHALL clear the index to 0 and go to LOAD on the next edge; start=0 SHALL hold IDLE.
REQ-014 LOAD SHALL drive readReg=index and, at the next edge, capture readData into dumpData, set dumpIdx=index and dumpValid=1, then go to SEND.
REQ-015 SEND SHALL hold dumpData, dumpIdx and dumpValid stable for as long as dumpReady=0.
REQ-016 A handshake (dumpValid=1 and dumpReady=1 at an edge) in SEND SHALL clear dumpValid; with index<31, the index SHALL increment by 1 and the FSM SHALL go to LOAD.
REQ-017 A handshake in SEND with index=31 SHALL go to DONE; with CHECKSUM_EN defined, the checksum word SHALL be emitted first per REQ-027.
REQ-018 DONE SHALL assert done for exactly one cycle and return to IDLE on the next edge.
REQ-019 start SHALL be ignored in LOAD, SEND and DONE.
REQ-020 Throughput SHALL be 2 cycles per word with dumpReady held high; a 32-word dump from start to done SHALL take 66 cycles: 1 IDLE, 64 LOAD/SEND, 1 DONE.
REQ-021 Each word SHALL reflect the register value at its own LOAD cycle; no whole-file snapshot is guaranteed.
REQ-022 A register-file write at the same edge as a LOAD capture SHALL yield the pre-write value.
REQ-023 dumpReady asserted while dumpValid=0 SHALL have no effect.
REQ-024 The index SHALL never exceed 31, and readReg SHALL never wrap within one dump.

Reset
REQ-025 rst=1 at an edge SHALL force IDLE from any state, including mid-dump with dumpValid=1, and SHALL set index=0, readReg=0, dumpData=0, dumpIdx=0, dumpValid=0, busy=0, done=0.
REQ-026 rst SHALL take priority over start and dumpReady in the same cycle; a partial dump SHALL NOT resume after reset.

Configuration
REQ-027 With macro REG_DUMP_CHECKSUM_EN defined, a 32-bit running XOR of all 32 captured words SHALL be kept, and after the handshake of index 31 it SHALL be presented with dumpIdx=32 and dumpValid=1 under the same SEND hold rules, going to DONE on its handshake; the dump SHALL then take 68 cycles.
REQ-028 The running XOR SHALL be cleared on start and on reset.
REQ-029 Without REG_DUMP_CHECKSUM_EN, no checksum logic SHALL exist, dumpIdx SHALL never equal 32, and DONE SHALL follow index 31 directly.

Verification
REQ-030 Register file preloaded with reg[i]=i*0x01010101, dumpReady=1, one-cycle start pulse -> 32 words in order, dumpIdx 0..31, dumpData matching, done pulse exactly 66 cycles after start (68 with checksum).
REQ-031 dumpReady low for 5 cycles on word 7 -> dumpData=0x07070707 and dumpIdx=7 held stable for all 5 cycles, no word lost or duplicated.
REQ-032 rst asserted in SEND at word 12 -> next cycle dumpValid=0 and busy=0; a new start restarts at dumpIdx=0.
REQ-033 start re-pulsed at word 3 and in DONE -> ignored, exactly 32 words and a single done pulse.
REQ-034 Checksum build, reg[i]=i -> word 32 equals XOR of 0..31 = 0x00000000; then with reg[5]=0xFFFFFFFF -> checksum 0xFFFFFFFA.
REQ-035 Writeback to reg 20 with value 0xDEADBEEF at the same edge as the word-20 capture -> dumpData holds the old value; a second dump shows 0xDEADBEEF.
